// File: rtl/multi_button_led_ctrl.sv
// N-channel button-to-LED controller: per-channel 2-FF synchroniser, debouncer,
// hold timer and mode logic (momentary / toggle / blink-toggle / short-long).
module multi_button_led_ctrl #(
  parameter int N_CH            = 4,
  parameter int DEBOUNCE_CYCLES = 100_000,
  parameter int LONG_CYCLES     = 10_000_000,
  parameter int BLINK_HALF      = 2_500_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   push_button,
  input  logic [2*N_CH-1:0] mode,
  output logic [N_CH-1:0]   led_out,
  output logic [N_CH-1:0]   btn_state,
  output logic [N_CH-1:0]   press_pulse,
  output logic [N_CH-1:0]   long_pulse
);

  localparam int DEB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HOLD_W  = $clog2(LONG_CYCLES + 1);
  localparam int BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0]  LONG_MAX   = HOLD_W'(LONG_CYCLES);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

  localparam logic [1:0] MODE_MOMENTARY = 2'b00;
  localparam logic [1:0] MODE_TOGGLE    = 2'b01;
  localparam logic [1:0] MODE_BLINK     = 2'b10;
  localparam logic [1:0] MODE_SHORTLONG = 2'b11;

  // Shared blink timebase; every blink-mode channel sees the same phase.
  logic [BLINK_W-1:0] blink_cnt_reg;
  logic               phase_reg;
  logic               phase_next;

  always_comb begin
    phase_next = phase_reg;
    if (blink_cnt_reg == BLINK_LAST) begin
      phase_next = ~phase_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blink_cnt_reg <= '0;
      phase_reg     <= 1'b0;
    end else begin
      if (blink_cnt_reg == BLINK_LAST) begin
        blink_cnt_reg <= '0;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + 1'b1;
      end
      phase_reg <= phase_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [1:0]        sync_reg;
      logic [DEB_W-1:0]  deb_cnt_reg;
      logic              btn_reg;
      logic [HOLD_W-1:0] hold_reg;
      logic [HOLD_W-1:0] hold_inc;
      logic [1:0]        mode_prev_reg;
      logic [1:0]        ch_mode;
      logic              st_reg;
      logic              st_next;
      logic              led_reg;
      logic              led_next;
      logic              pulse_reg;
      logic              long_reg;
      logic              mode_chg;
      logic              settle;
      logic              rise_evt;
      logic              fall_evt;
      logic              long_evt;

      always_comb begin
        ch_mode  = mode[2*gi +: 2];
        mode_chg = (ch_mode != mode_prev_reg);

        // The debounced level flips this cycle; rise/fall coincide with the flip.
        settle   = (sync_reg[1] != btn_reg) && (deb_cnt_reg == DEB_LAST);
        rise_evt = settle && sync_reg[1];
        fall_evt = settle && !sync_reg[1];

        hold_inc = (hold_reg == LONG_MAX) ? hold_reg : hold_reg + 1'b1;
        long_evt = btn_reg && (hold_reg != LONG_MAX) && (hold_inc == LONG_MAX);

        st_next  = st_reg;
        led_next = 1'b0;
        if (mode_chg) begin
          st_next  = 1'b0;
          led_next = 1'b0;
        end else begin
          case (ch_mode)
            MODE_MOMENTARY: begin
              st_next  = 1'b0;
              led_next = btn_reg;
            end
            MODE_TOGGLE: begin
              if (rise_evt) st_next = ~st_reg;
              led_next = st_next;
            end
            MODE_BLINK: begin
              if (rise_evt) st_next = ~st_reg;
              led_next = st_next & phase_next;
            end
            default: begin
              // A release that also completes the long hold counts as long, not short.
              if (long_evt) begin
                st_next = 1'b0;
              end else if (fall_evt && (hold_inc != LONG_MAX)) begin
                st_next = ~st_reg;
              end
              led_next = st_next;
            end
          endcase
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          sync_reg      <= 2'b00;
          deb_cnt_reg   <= '0;
          btn_reg       <= 1'b0;
          hold_reg      <= '0;
          mode_prev_reg <= 2'b00;
          st_reg        <= 1'b0;
          led_reg       <= 1'b0;
          pulse_reg     <= 1'b0;
          long_reg      <= 1'b0;
        end else begin
          sync_reg <= {sync_reg[0], push_button[gi]};

          if (sync_reg[1] == btn_reg) begin
            deb_cnt_reg <= '0;
          end else if (deb_cnt_reg == DEB_LAST) begin
            btn_reg     <= sync_reg[1];
            deb_cnt_reg <= '0;
          end else begin
            deb_cnt_reg <= deb_cnt_reg + 1'b1;
          end

          if (!btn_reg) begin
            hold_reg <= '0;
          end else begin
            hold_reg <= hold_inc;
          end

          mode_prev_reg <= ch_mode;
          st_reg        <= st_next;
          led_reg       <= led_next;
          pulse_reg     <= rise_evt;
          long_reg      <= long_evt && (ch_mode == MODE_SHORTLONG) && !mode_chg;
        end
      end

      assign led_out[gi]     = led_reg;
      assign btn_state[gi]   = btn_reg;
      assign press_pulse[gi] = pulse_reg;
      assign long_pulse[gi]  = long_reg;
    end
  endgenerate

endmodule

// File: tb/tb_multi_button_led_ctrl.sv
// Bench for multi_button_led_ctrl: directed scenarios followed by random presses,
// checked against a press-level model of the LED/pulse behaviour.
module tb_multi_button_led_ctrl;
  localparam int N_CH  = 4;
  localparam int DEB   = 8;
  localparam int LONG  = 32;
  localparam int BLINK = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] push_button;
  logic [7:0] mode;
  logic [3:0] led_out;
  logic [3:0] btn_state;
  logic [3:0] press_pulse;
  logic [3:0] long_pulse;

  multi_button_led_ctrl #(
    .N_CH(N_CH),
    .DEBOUNCE_CYCLES(DEB),
    .LONG_CYCLES(LONG),
    .BLINK_HALF(BLINK)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .push_button(push_button),
    .mode(mode),
    .led_out(led_out),
    .btn_state(btn_state),
    .press_pulse(press_pulse),
    .long_pulse(long_pulse)
  );

  always #50 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int press_cnt [4];
  int long_cnt  [4];
  int exp_press [4];
  int exp_long  [4];
  logic       st_m   [4];
  logic [1:0] mode_m [4];

  // cyc = number of clock edges since reset was released (drives the blink phase model)
  always @(posedge clk) begin
    cyc <= rst_n ? cyc + 1 : 0;
    for (int i = 0; i < 4; i++) begin
      if (press_pulse[i] === 1'b1) press_cnt[i] <= press_cnt[i] + 1;
      if (long_pulse[i] === 1'b1) long_cnt[i] <= long_cnt[i] + 1;
    end
  end

  initial begin
    #(100 * 50000);
    $display("FAIL watchdog: simulation did not finish within 50000 cycles");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [3:0] exp_led();
    logic [3:0] e;
    logic ph;
    ph = ((cyc / BLINK) % 2) == 1;
    for (int i = 0; i < 4; i++) begin
      case (mode_m[i])
        2'd0:    e[i] = 1'b0;
        2'd2:    e[i] = st_m[i] & ph;
        default: e[i] = st_m[i];
      endcase
    end
    return e;
  endfunction

  // Effect of one clean press of p cycles on each channel in mask.
  task automatic account(input logic [3:0] mask, input int p);
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) begin
        exp_press[i]++;
        case (mode_m[i])
          2'd0: st_m[i] = 1'b0;
          2'd3: begin
            if (p >= LONG) begin
              st_m[i] = 1'b0;
              exp_long[i]++;
            end else begin
              st_m[i] = ~st_m[i];
            end
          end
          default: st_m[i] = ~st_m[i];
        endcase
      end
    end
  endtask

  task automatic press(input logic [3:0] mask, input int p);
    push_button = mask;
    wait_cyc(p);
    push_button = 4'h0;
    wait_cyc(14);
    account(mask, p);
  endtask

  task automatic set_modes(input logic [7:0] m);
    for (int i = 0; i < 4; i++) begin
      if (m[2*i +: 2] != mode_m[i]) begin
        st_m[i]   = 1'b0;
        mode_m[i] = m[2*i +: 2];
      end
    end
    mode = m;
    wait_cyc(2);
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "_led"}, 32'(led_out), 32'(exp_led()));
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_press%0d", tag, i), press_cnt[i], exp_press[i]);
      chk($sformatf("%s_long%0d", tag, i), long_cnt[i], exp_long[i]);
    end
  endtask

  logic [3:0] e;
  logic [7:0] rnd_mode;
  logic [3:0] rnd_mask;
  int         rnd_p;

  initial begin
    for (int i = 0; i < 4; i++) begin
      st_m[i] = 1'b0;
      mode_m[i] = 2'd0;
      exp_press[i] = 0;
      exp_long[i] = 0;
    end

    // Reset with all buttons held, then timed acceptance after release of reset
    rst_n = 1'b0;
    push_button = 4'hF;
    mode = 8'h00;
    wait_cyc(3);
    chk("reset_outputs", 32'({led_out, btn_state, press_pulse, long_pulse}), 32'h0);
    rst_n = 1'b1;
    wait_cyc(9);
    chk("rst_btn_early", 32'(btn_state), 32'h0);
    wait_cyc(1);
    chk("rst_btn_at10", 32'(btn_state), 32'hF);
    chk("rst_press_at10", 32'(press_pulse), 32'hF);
    chk("rst_led_lag", 32'(led_out), 32'h0);
    wait_cyc(1);
    chk("rst_led_follow", 32'(led_out), 32'hF);
    chk("rst_press_single", 32'(press_pulse), 32'h0);
    push_button = 4'h0;
    wait_cyc(14);
    account(4'hF, 11);
    chk_all("rst");

    // Bounce on ch0 in toggle mode
    set_modes(8'h01);
    push_button = 4'b0001;
    wait_cyc(5);
    push_button = 4'b0000;
    wait_cyc(2);
    push_button = 4'b0001;
    wait_cyc(20);
    push_button = 4'b0000;
    wait_cyc(14);
    account(4'b0001, 20);
    chk_all("bounce");
    press(4'b0001, 12);
    chk_all("toggle_off");

    // Momentary on ch1
    push_button = 4'b0010;
    wait_cyc(10);
    chk("mom_rise", 32'({btn_state[1], led_out[1]}), 32'h2);
    wait_cyc(1);
    chk("mom_led_on", 32'(led_out[1]), 32'h1);
    wait_cyc(4);
    push_button = 4'b0000;
    wait_cyc(10);
    chk("mom_fall", 32'({btn_state[1], led_out[1]}), 32'h1);
    wait_cyc(1);
    chk("mom_led_off", 32'(led_out[1]), 32'h0);
    wait_cyc(3);
    exp_press[1]++;

    // Blink-toggle on ch2
    set_modes(8'b0010_0001);
    press(4'b0100, 12);
    for (int k = 0; k < 8; k++) begin
      wait_cyc(1);
      e = exp_led();
      chk($sformatf("blink_on%0d", k), 32'(led_out[2]), 32'(e[2]));
    end
    press(4'b0100, 12);
    for (int k = 0; k < 8; k++) begin
      wait_cyc(1);
      chk($sformatf("blink_off%0d", k), 32'(led_out[2]), 32'h0);
    end

    // Short then long press on ch3
    set_modes(8'b1110_0001);
    press(4'b1000, 10);
    chk_all("short");
    push_button = 4'b1000;
    wait_cyc(40);
    push_button = 4'b0000;
    wait_cyc(1);
    chk("long_before", 32'(long_pulse), 32'h0);
    wait_cyc(1);
    chk("long_at32", 32'(long_pulse), 32'h8);
    wait_cyc(1);
    chk("long_single", 32'(long_pulse), 32'h0);
    wait_cyc(12);
    account(4'b1000, 40);
    chk_all("long");

    // Mode change clears the LED on the next cycle; then simultaneous presses
    press(4'b0001, 12);
    chk_all("pre_modechg");
    mode = 8'b1110_0010;
    mode_m[0] = 2'd2;
    st_m[0] = 1'b0;
    wait_cyc(1);
    chk("modechg_led0", 32'(led_out[0]), 32'h0);
    wait_cyc(1);
    push_button = 4'hF;
    wait_cyc(10);
    chk("simul_press", 32'(press_pulse), 32'hF);
    wait_cyc(2);
    push_button = 4'h0;
    wait_cyc(14);
    account(4'hF, 12);
    chk_all("simul");

    // Reset in the middle of a ch3 hold
    push_button = 4'b1000;
    wait_cyc(20);
    rst_n = 1'b0;
    exp_press[3]++;
    wait_cyc(1);
    chk("midrst_outputs", 32'({led_out, btn_state, press_pulse, long_pulse}), 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) st_m[i] = 1'b0;
    wait_cyc(9);
    chk("midrst_btn_early", 32'(btn_state[3]), 32'h0);
    wait_cyc(1);
    chk("midrst_btn_at10", 32'(btn_state[3]), 32'h1);
    wait_cyc(11);
    chk("midrst_no_long", 32'(long_pulse), 32'h0);
    wait_cyc(3);
    push_button = 4'b0000;
    wait_cyc(14);
    account(4'b1000, 24);
    chk_all("midrst");

    // Random modes, channel masks and press lengths
    for (int r = 0; r < 12; r++) begin
      rnd_mode = 8'($urandom);
      set_modes(rnd_mode);
      rnd_mask = 4'($urandom_range(1, 15));
      rnd_p = ($urandom_range(0, 1) == 1) ? int'($urandom_range(40, 55)) : int'($urandom_range(10, 25));
      press(rnd_mask, rnd_p);
      chk_all($sformatf("rnd%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
